// File: rtl/edge_detect_multi.sv
// Multi-channel button front end: synchroniser, counter debounce, mode-gated
// edge pulses and an optional hold-to-repeat timer per channel.
module edge_detect_multi #(
  parameter int N_CH          = 5,
  parameter int SYNC_STAGES   = 2,
  parameter int DEB_CYCLES    = 16,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic                iClk,
  input  logic                iRst_n,
  input  logic [N_CH-1:0]     iSig,
  input  logic [2*N_CH-1:0]   iMode,
  input  logic [N_CH-1:0]     iRepeatEn,
  output logic [N_CH-1:0]     oLevel,
  output logic [N_CH-1:0]     oPulse,
  output logic [N_CH-1:0]     oRepeat,
  output logic [2*N_CH-1:0]   oState
);

  localparam int DW   = $clog2(DEB_CYCLES + 1);
  localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rep_state_e;

  for (genvar k = 0; k < N_CH; k++) begin : gCh
    logic [SYNC_STAGES-1:0] syncQ;
    logic                   syncBit;
    logic [DW-1:0]          debCnt;
    logic                   stable;
    logic                   flip;
    logic                   riseFlip;
    logic                   fallFlip;
    logic [1:0]             mode;
    logic                   edgeHit;
    logic                   repeatOk;
    logic                   leaveRepeat;
    rep_state_e             state;
    rep_state_e             stateNext;
    logic [TW-1:0]          timer;
    logic [TW-1:0]          timerNext;
    logic                   repFire;
    logic                   pulseQ;
    logic                   repeatQ;

    assign syncBit = syncQ[SYNC_STAGES-1];
    assign mode    = iMode[2*k +: 2];

    always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) syncQ <= '0;
      else         syncQ <= {syncQ[SYNC_STAGES-2:0], iSig[k]};
    end

    // Flip on the edge where the disagreement run reaches DEB_CYCLES samples.
    assign flip     = (syncBit != stable) && (debCnt == DEB_LAST);
    assign riseFlip = flip && !stable;
    assign fallFlip = flip && stable;

    always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
        stable <= 1'b0;
        debCnt <= '0;
      end else if (syncBit != stable) begin
        if (debCnt == DEB_LAST) begin
          stable <= ~stable;
          debCnt <= '0;
        end else begin
          debCnt <= debCnt + DW'(1);
        end
      end else begin
        debCnt <= '0;
      end
    end

    always_comb begin
      edgeHit = 1'b0;
      case (mode)
        2'b00:   edgeHit = riseFlip;
        2'b01:   edgeHit = fallFlip;
        2'b10:   edgeHit = riseFlip || fallFlip;
        default: edgeHit = 1'b0;
      endcase
    end

    assign repeatOk    = iRepeatEn[k] && ((mode == 2'b00) || (mode == 2'b10));
    assign leaveRepeat = fallFlip || !repeatOk;

    always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
        state <= IDLE;
        timer <= '0;
      end else begin
        state <= stateNext;
        timer <= timerNext;
      end
    end

    always_comb begin
      stateNext = state;
      timerNext = timer;
      case (state)
        IDLE: begin
          if (riseFlip && repeatOk) begin
            stateNext = HOLD;
            timerNext = '0;
          end
        end
        HOLD: begin
          if (leaveRepeat) begin
            stateNext = IDLE;
            timerNext = '0;
          end else if (timer == HOLD_LAST) begin
            stateNext = REPEAT;
            timerNext = '0;
          end else begin
            timerNext = timer + TW'(1);
          end
        end
        REPEAT: begin
          if (leaveRepeat) begin
            stateNext = IDLE;
            timerNext = '0;
          end else if (timer == REP_LAST) begin
            timerNext = '0;
          end else begin
            timerNext = timer + TW'(1);
          end
        end
        default: begin
          stateNext = IDLE;
          timerNext = '0;
        end
      endcase
    end

    // A release (or enable/mode drop) wins over a timer expiry in the same cycle.
    always_comb begin
      repFire = 1'b0;
      case (state)
        HOLD:    repFire = !leaveRepeat && (timer == HOLD_LAST);
        REPEAT:  repFire = !leaveRepeat && (timer == REP_LAST);
        default: repFire = 1'b0;
      endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
        pulseQ  <= 1'b0;
        repeatQ <= 1'b0;
      end else begin
        pulseQ  <= edgeHit || repFire;
        repeatQ <= repFire;
      end
    end

    assign oLevel[k]       = stable;
    assign oPulse[k]       = pulseQ;
    assign oRepeat[k]      = repeatQ;
    assign oState[2*k +: 2] = state;
  end

endmodule
